// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared types for the serial magnitude comparator.
//   state_t   : controller FSM states (IDLE / RUN / DONE)
//   SLICE_W   : width of one comparator slice, in bits
//   cmp_res_t : one-hot compare result {eq, gt, lt}
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Request/result bundle of serial_cmp_ctrl.
//   start, clear, a, b        : requester -> controller
//   busy, done, eq, gt, lt    : controller -> requester
// master = requester side, slave = controller side.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, clear, a, b,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, clear, a, b,
    output busy, done, eq, gt, lt
  );

endinterface

// File: rtl/serial_cmp_ctrl_slice2.sv
// cmp_slice2: purely combinational unsigned compare of two 2-bit slices.
//   a, b : slice operands
//   res  : one-hot {eq, gt, lt}
module cmp_slice2
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output cmp_res_t           res
);

  always_comb begin
    res.eq = (a == b);
    res.gt = (a > b);
    res.lt = (a < b);
  end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: compares two WIDTH-bit unsigned operands by walking a single
// 2-bit comparator slice from the MSB slice down to slice 0.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_cmp_ctrl_if.slave
//            start/clear/a/b in; busy/done/eq/gt/lt out (all registered)
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN: leave RUN on the edge that
// processes the first unequal slice instead of always spending NSLICE cycles.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_cmp_ctrl_if.slave   bus
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_cmp_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t           state,   state_nxt;
  logic [WIDTH-1:0] a_q,     a_nxt;
  logic [WIDTH-1:0] b_q,     b_nxt;
  logic [IDX_W-1:0] idx,     idx_nxt;
  logic             decided, decided_nxt;  // an unequal slice has been seen
  cmp_res_t         acc,     acc_nxt;      // gt/lt of that first unequal slice
  cmp_res_t         res_q,   res_nxt;      // result presented on eq/gt/lt
  logic             busy_q,  done_q;

  logic [SLICE_W-1:0] a_sl, b_sl;
  cmp_res_t           sl_res;

  assign a_sl = a_q[SLICE_W*idx +: SLICE_W];
  assign b_sl = b_q[SLICE_W*idx +: SLICE_W];

  cmp_slice2 u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .res (sl_res)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_nxt   = state;
    a_nxt       = a_q;
    b_nxt       = b_q;
    idx_nxt     = idx;
    decided_nxt = decided;
    acc_nxt     = acc;
    res_nxt     = res_q;

    if (bus.clear) begin
      // Abort beats start and RUN completion; the results are wiped too.
      state_nxt   = IDLE;
      decided_nxt = 1'b0;
      res_nxt     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_nxt       = bus.a;
            b_nxt       = bus.b;
            idx_nxt     = IDX_W'(NSLICE - 1);
            decided_nxt = 1'b0;
            acc_nxt     = '0;
            res_nxt     = '0;
            state_nxt   = RUN;
          end
        end

        RUN: begin
          // Only the first unequal slice (scanning from MSB) decides.
          if (!decided && !sl_res.eq) begin
            decided_nxt = 1'b1;
            acc_nxt     = sl_res;
          end
          if ((idx == '0) || (EARLY_EXIT && decided_nxt)) begin
            state_nxt = DONE;
            res_nxt   = decided_nxt ? acc_nxt : '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
            idx_nxt   = '0;
          end else begin
            idx_nxt   = idx - 1'b1;
          end
        end

        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      acc     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      idx     <= idx_nxt;
      decided <= decided_nxt;
      acc     <= acc_nxt;
      res_q   <= res_nxt;
      busy_q  <= (state_nxt == RUN);
      done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = res_q.eq;
  assign bus.gt   = res_q.gt;
  assign bus.lt   = res_q.lt;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl (WIDTH=8). Expected results come from
// a vector table and a latency model; a scoreboard queue carries expectations
// from the start of each compare to its done pulse.
module tb_serial_cmp_ctrl;

  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;

  logic clk;
  logic rst_n;

  serial_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       eq;
    logic       gt;
    logic       lt;
  } vec_t;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycles from the accepting edge to the done cycle.
  function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [7:0] av, bv;
    lat = NSLICE;
    av  = a;
    bv  = b;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int k = NSLICE - 1; k >= 0; k--) begin
      if (av[2*k +: 2] != bv[2*k +: 2]) begin
        lat = NSLICE - k;
        break;
      end
    end
`else
    if (av == bv) lat = NSLICE;
`endif
    return lat;
  endfunction

  // Issue one compare from IDLE, wait for done, check result/latency/busy,
  // then check the result is held in the following IDLE cycle.
  task automatic do_cmp(input logic [7:0] a, input logic [7:0] b,
                        input logic e_eq, input logic e_gt, input logic e_lt,
                        input string name);
    exp_t e;
    int   cyc;
    int   busy_cyc;
    e.eq  = e_eq;
    e.gt  = e_gt;
    e.lt  = e_lt;
    e.lat = exp_latency(a, b);
    sb.push_back(e);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = ~a;   // operands must have been latched on the accepting edge
    bus.b     = ~b;
    cyc       = 0;
    busy_cyc  = 0;
    while (bus.done !== 1'b1 && cyc < 50) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    if (bus.done !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end else begin
      check({name, " latency"}, cyc, e.lat);
      check({name, " busy_cycles"}, busy_cyc, e.lat);
      check({name, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      check({name, " result"}, {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, e.eq, e.gt, e.lt});
      @(posedge clk); #1;
      check({name, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
      check({name, " result_held"}, {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, e.eq, e.gt, e.lt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    int t1, t2, n_done;
    logic prev_done, overlap;

    vecs[0] = '{a: 8'hA5, b: 8'hA5, eq: 1'b1, gt: 1'b0, lt: 1'b0};
    vecs[1] = '{a: 8'hC0, b: 8'h80, eq: 1'b0, gt: 1'b1, lt: 1'b0};
    vecs[2] = '{a: 8'h01, b: 8'h02, eq: 1'b0, gt: 1'b0, lt: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'h00, eq: 1'b0, gt: 1'b1, lt: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'hFF, eq: 1'b0, gt: 1'b0, lt: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, eq: 1'b1, gt: 1'b0, lt: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'h80, eq: 1'b0, gt: 1'b0, lt: 1'b1};
    vecs[7] = '{a: 8'h3D, b: 8'h3C, eq: 1'b0, gt: 1'b1, lt: 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    #12;
    check("reset outputs", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven compares.
    for (int i = 0; i < 8; i++) begin
      do_cmp(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].gt, vecs[i].lt,
             $sformatf("vec%0d", i));
    end

    // start held high across two operations; operands changed during RUN.
    bus.a     = 8'hC0;
    bus.b     = 8'h80;
    bus.start = 1'b1;
    t1        = -1;
    t2        = -1;
    n_done    = 0;
    prev_done = 1'b0;
    overlap   = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        bus.a = 8'h01;
        bus.b = 8'h02;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (prev_done) overlap = 1'b1;
        if (t1 < 0) begin
          t1 = t;
          check("held_start op1 result", {29'd0, bus.eq, bus.gt, bus.lt}, 32'b010);
        end else if (t2 < 0) begin
          t2 = t;
          check("held_start op2 result", {29'd0, bus.eq, bus.gt, bus.lt}, 32'b001);
          bus.start = 1'b0;
        end
      end
      if (t1 >= 0 && t == t1 + 1)
        check("held_start idle gap busy", {31'd0, bus.busy}, 32'd0);
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    check("held_start op1 latency", t1, exp_latency(8'hC0, 8'h80));
    check("held_start op2 accept gap", t2 - t1, 2 + exp_latency(8'h01, 8'h02));
    check("held_start done pulses", n_done, 2);
    check("held_start no done overlap", {31'd0, overlap}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in RUN cycle 2.
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 32'd0);
    @(posedge clk); #1;
    check("reset held outputs", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmp(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, "post_reset");

    // clear in RUN cycle 3 aborts with no done pulse.
    bus.a     = 8'h3C;
    bus.b     = 8'h3D;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("clear_run busy before", {31'd0, bus.busy}, 32'd1);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    check("clear_run outputs", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 32'd0);
    n_done = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
    end
    check("clear_run no later activity", n_done, 0);

    // clear + start in IDLE: start ignored, held result cleared.
    do_cmp(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, "pre_clear_idle");
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.start = 1'b1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check("clear_idle outputs", {27'd0, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 32'd0);
    n_done = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
    end
    check("clear_idle start ignored", n_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
